io_stream_driver: RTL
=====================

IO_STREAM_DRIVER -- requirements
Module: io_stream_driver

Interface
REQ-001 SHALL have parameter IO_DATA_WIDTH, default 16, meaning the width of the a/b stream words.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16 (power of 2, >=2), meaning the entries per lane FIFO.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, meaning the width of all counters.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the idle-cycle limit for the watchdog.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port arst_n_in, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports host_a_data / host_b_data, input, IO_DATA_WIDTH: host words for lane a / lane b.
REQ-008 SHALL have ports host_a_push / host_b_push, input, 1 bit: host write strobe per lane.
REQ-009 SHALL have ports host_a_full / host_b_full, output, 1 bit: lane FIFO full.
REQ-010 SHALL have port go, input, 1 bit: one-cycle request to run a job.
REQ-011 SHALL have port nb_outputs_expected, input, CNT_WIDTH: the number of output beats that completes a job.
REQ-012 SHALL have ports a_input / b_input, output, IO_DATA_WIDTH: stream data to the accelerator.
REQ-013 SHALL have ports a_valid / b_valid, output, 1 bit, and a_ready / b_ready, input, 1 bit: the per-lane handshake.
REQ-014 SHALL have port start, output, 1 bit, and port running, input, 1 bit: accelerator control/status.
REQ-015 SHALL have port output_valid, input, 1 bit: accelerator result beat.
REQ-016 SHALL have outputs busy, done, error (1 bit each) and a_sent_cnt, b_sent_cnt, out_rx_cnt (CNT_WIDTH each).

Function
REQ-017 SHALL implement FSM states IDLE, START, STREAM, DONE.
REQ-018 IDLE: go -> START; counters a_sent_cnt, b_sent_cnt, out_rx_cnt and error clear in the same edge.
REQ-019 START: start=1 for exactly one cycle; next state is always STREAM.
REQ-020 STREAM exits to DONE when out_rx_cnt==nb_outputs_expected && running==0; with expected=0 and running low this occurs on the first STREAM cycle.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in START/STREAM/DONE, 0 in IDLE.
REQ-022 go SHALL be ignored outside IDLE.
REQ-023 Each lane SHALL have an independent FIFO accepting host pushes in any state; a push while full is dropped and leaves contents unchanged.
REQ-024 full SHALL be evaluated before the same-cycle pop, so push+pop while full drops the push; push+pop while non-full-non-empty keeps the count.
REQ-025 x_valid = (state==STREAM) && FIFO non-empty; x_input = FIFO head, held stable while x_valid && !x_ready.
REQ-026 A beat transfers on x_valid && x_ready; it pops the FIFO and increments x_sent_cnt; the lanes are fully independent.
REQ-027 out_rx_cnt increments on output_valid only in STREAM; it saturates at all-ones.
REQ-028 Counters hold their values from DONE until the next accepted go.
REQ-029 Data in the FIFOs at exit from STREAM SHALL be retained for the next job.

Reset
REQ-030 On arst_n_in low, state=IDLE immediately, FIFOs empty, and all counters 0.
REQ-031 During reset, start, busy, done, error, a_valid and b_valid are 0, and a_input/b_input are 0.
REQ-032 Reset mid-STREAM SHALL abort the job with no done pulse; the first legal go is on the cycle after deassertion.

Configuration
REQ-033 With IO_STREAM_DRIVER_TIMEOUT_EN defined, a watchdog SHALL count STREAM cycles with no lane transfer and no output_valid; reaching TIMEOUT_CYCLES forces DONE with error=1, held until the next accepted go.
REQ-034 Without IO_STREAM_DRIVER_TIMEOUT_EN, no watchdog is built, error is tied 0, and STREAM exits only per REQ-020.

Verification
REQ-035 Push 3 words 0x0001..0x0003 into lane a, go, a_ready=1 -> start pulse 1 cycle after go; a_input 1,2,3 on consecutive cycles; a_sent_cnt=3.
REQ-036 In STREAM, toggle a_ready 0/1 each cycle with 4 words queued -> a_input holds each value until accepted; no loss or duplication; a_sent_cnt=4.
REQ-037 Fill lane b to 16, then push 0xBEEF while b_ready=0 -> host_b_full=1, push dropped; the drain emits only the original 16 words.
REQ-038 nb_outputs_expected=5, 5 output_valid beats, then running falls -> done pulses exactly once on the cycle after running low; out_rx_cnt=5; busy falls with done.
REQ-039 Assert arst_n_in mid-STREAM with 6 words queued -> valids drop asynchronously; afterwards FIFOs are empty, counters are 0, and there is no done pulse.
REQ-040 With IO_STREAM_DRIVER_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, hold a_ready=b_ready=0 with no output_valid -> DONE after 8 idle STREAM cycles and error=1; without the macro -> the driver remains in STREAM.

Source files
------------

// File: rtl/io_stream_driver_if.sv
// Two-lane valid/ready stream between io_stream_driver (master) and the accelerator (slave).
interface io_stream_driver_if #(
  parameter int IO_DATA_WIDTH = 16
);
  logic [IO_DATA_WIDTH-1:0] a_input;
  logic                     a_valid;
  logic                     a_ready;
  logic [IO_DATA_WIDTH-1:0] b_input;
  logic                     b_valid;
  logic                     b_ready;

  modport master (output a_input, a_valid, b_input, b_valid, input a_ready, b_ready);
  modport slave  (input a_input, a_valid, b_input, b_valid, output a_ready, b_ready);
endinterface

// File: rtl/io_stream_driver.sv
// Job sequencer draining two host-filled FIFOs into the accelerator's a/b stream lanes.
// Optional stall watchdog: define IO_STREAM_DRIVER_TIMEOUT_EN to abort idle jobs with error=1.
module io_stream_driver #(
  parameter int IO_DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic [IO_DATA_WIDTH-1:0] host_a_data,
  input  logic [IO_DATA_WIDTH-1:0] host_b_data,
  input  logic                     host_a_push,
  input  logic                     host_b_push,
  output logic                     host_a_full,
  output logic                     host_b_full,
  input  logic                     go,
  input  logic [CNT_WIDTH-1:0]     nb_outputs_expected,
  io_stream_driver_if.master       strm,
  output logic                     start,
  input  logic                     running,
  input  logic                     output_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [CNT_WIDTH-1:0]     a_sent_cnt,
  output logic [CNT_WIDTH-1:0]     b_sent_cnt,
  output logic [CNT_WIDTH-1:0]     out_rx_cnt
);
  localparam int                   PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]       FILL_MAX = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]       FILL_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("io_stream_driver: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, STREAM, DONE} state_t;
  state_t state;

  // Lane 0 is a, lane 1 is b; both lanes share identical FIFO logic.
  logic [IO_DATA_WIDTH-1:0] mem [2][FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr [2];
  logic [PTR_W-1:0]         rd_ptr [2];
  logic [PTR_W:0]           fill [2];
  logic [IO_DATA_WIDTH-1:0] wdata [2];
  logic [IO_DATA_WIDTH-1:0] head [2];
  logic                     push [2];
  logic                     ready [2];
  logic                     nonempty [2];
  logic                     accept [2];
  logic                     pop [2];
  logic                     go_accept, stream_exit, rx_beat, timeout;

  assign wdata[0] = host_a_data;
  assign wdata[1] = host_b_data;
  assign push[0]  = host_a_push;
  assign push[1]  = host_b_push;
  assign ready[0] = strm.a_ready;
  assign ready[1] = strm.b_ready;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    assign nonempty[i] = (fill[i] != '0);
    // Full is judged on the pre-pop fill, so a push into a full FIFO is dropped even if it pops.
    assign accept[i]   = push[i] && (fill[i] != FILL_MAX);
    assign pop[i]      = (state == STREAM) && nonempty[i] && ready[i];
    assign head[i]     = nonempty[i] ? mem[i][rd_ptr[i]] : '0;
  end

  assign host_a_full  = (fill[0] == FILL_MAX);
  assign host_b_full  = (fill[1] == FILL_MAX);
  assign strm.a_valid = (state == STREAM) && nonempty[0];
  assign strm.b_valid = (state == STREAM) && nonempty[1];
  assign strm.a_input = head[0];
  assign strm.b_input = head[1];

  assign go_accept   = (state == IDLE) && go;
  assign stream_exit = (state == STREAM) && (out_rx_cnt == nb_outputs_expected) && !running;
  assign rx_beat     = (state == STREAM) && output_valid && (out_rx_cnt != '1);

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state      <= IDLE;
      start      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      a_sent_cnt <= '0;
      b_sent_cnt <= '0;
      out_rx_cnt <= '0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      if (pop[0])  a_sent_cnt <= a_sent_cnt + CNT_ONE;
      if (pop[1])  b_sent_cnt <= b_sent_cnt + CNT_ONE;
      if (rx_beat) out_rx_cnt <= out_rx_cnt + CNT_ONE;
      case (state)
        IDLE: if (go_accept) begin
          state      <= START;
          start      <= 1'b1;
          busy       <= 1'b1;
          a_sent_cnt <= '0;
          b_sent_cnt <= '0;
          out_rx_cnt <= '0;
        end
        START:  state <= STREAM;
        STREAM: if (stream_exit || timeout) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; fill==0 masks stale words and lets this map onto RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (accept[i]) mem[i][wr_ptr[i]] <= wdata[i];
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        fill[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (pop[i])    rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        if (accept[i] && !pop[i])      fill[i] <= fill[i] + FILL_ONE;
        else if (!accept[i] && pop[i]) fill[i] <= fill[i] - FILL_ONE;
      end
    end
  end

`ifdef IO_STREAM_DRIVER_TIMEOUT_EN
  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              activity;

  assign activity = pop[0] || pop[1] || output_valid;
  // Fires on the TIMEOUT_CYCLES-th consecutive idle STREAM cycle.
  assign timeout  = (state == STREAM) && !activity && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      idle_cnt <= '0;
      error    <= 1'b0;
    end else begin
      if (state != STREAM || activity) idle_cnt <= '0;
      else                             idle_cnt <= idle_cnt + IDLE_ONE;
      if (go_accept)                    error <= 1'b0;
      else if (timeout && !stream_exit) error <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule
